e1ofn_rtl_bridge: RTL and testbench
===================================

// Module: e1ofn_rtl_bridge
// PURPOSE
//  Bridges one enable-based M-digit 1-of-N (e1ofN) asynchronous channel pair to clocked RTL handshakes.
//  - Receive path: decodes an e1ofN input token into a binary word with a valid/ready handshake.
//  - Send path: encodes a binary word from a valid/ready handshake onto an e1ofN output.
//  - Sits between async NoC channels and synthesized RTL bodies (e.g. router/decoder logic).
// PARAMETERS
//  M   9  number of 1-of-N digits per token
//  N   2  rails per digit (radix), N>=2
//  W   M*$clog2(N)  derived (localparam): binary word width; digit i -> bits [i*$clog2(N) +: $clog2(N)]
// PORTS
//  CLK       in   1    single clock; all logic on posedge CLK
//  _RESET    in   1    synchronous, ACTIVE-HIGH reset (name kept per codebase; polarity/sync fixed)
//  in_rails  in   M*N  receive rails; digit i rail v = in_rails[i*N+v]
//  in_e      out  1    receive enable (1 = ready for data, 0 = acknowledge)
//  rcv_data  out  W    decoded word
//  rcv_valid out  1    rcv_data valid
//  rcv_ready in   1    RTL consumer accepts when rcv_valid&rcv_ready
//  snd_data  in   W    word to transmit
//  snd_valid in   1    RTL producer offers snd_data
//  snd_ready out  1    transfer occurs when snd_valid&snd_ready
//  out_rails out  M*N  send rails, same digit/rail mapping
//  out_e     in   1    send enable from async receiver
// BEHAVIOUR
//  Reset (sync, _RESET=1 at posedge): in_e=1, rcv_valid=0, rcv_data=0, out_rails=0, snd_ready=0; FSMs to idle; aborts any token mid-flight.
//  Token complete: every digit exactly one rail high. Neutral: all rails 0. Multi-hot digit: treated as incomplete (wait, no capture).
//  Receive FSM:
//   - RX_WAIT: in_e=1. Complete token sampled and rcv_valid==0 -> capture decoded word into rcv_data, rcv_valid=1, in_e=0, go RX_ACK (1-cycle latency).
//   - RX_ACK: in_e=0. All rails neutral -> RX_WAIT.
//   - Complete token while rcv_valid==1: not captured; stays in RX_WAIT with in_e=1 (backpressure) until consumer takes buffered word.
//  rcv_valid clears on rcv_valid&rcv_ready. Simultaneous consume and new complete token in one cycle: capture allowed (single buffer, no bubble).
//  Send FSM:
//   - TX_IDLE: out_rails=0; snd_ready=1 iff sampled out_e==1. snd_valid&snd_ready -> register snd_data, drive one-hot rails next cycle, go TX_DATA.
//   - TX_DATA: rails hold the encoded word. Sampled out_e==0 -> rails to 0, go TX_NEUT.
//   - TX_NEUT: rails 0, snd_ready=0. Sampled out_e==1 -> TX_IDLE.
//  Encode/decode: digit value = index of hot rail; digit 0 least significant. For N not a power of 2, digit values >=N on snd_data are clamped to N-1.
//  All outputs registered; no combinational path from async inputs to outputs.
// CONFIGURATION
//  E1OFN_SYNC_EN defined: in_rails and out_e pass through 2-flop synchronizers; adds 2 cycles receive/ack latency.
//  Not defined: inputs sampled directly at posedge (for simulation or already-synchronous fabric); latencies as above.
// STRUCTURE
//  Package e1ofn_pkg:
//   - rx_state_t {RX_WAIT,RX_ACK}, tx_state_t {TX_IDLE,TX_DATA,TX_NEUT}
//   - functions onehot_digit_to_bin, bin_to_onehot_digit, token_complete, token_neutral
//  Sub-module e1ofn_sync: parameterized-width 2-flop synchronizer, instantiated only under E1OFN_SYNC_EN.
// TESTING
//  1 Reset: assert _RESET 2 cycles mid-token -> in_e=1, rcv_valid=0, out_rails=0 next cycle.
//  2 M=9,N=2 receive: rails encode 9'h1A5 (pair0 rail1 high...) -> rcv_data=9'h1A5, rcv_valid=1, in_e=0; neutral rails -> in_e=1.
//  3 Backpressure: rcv_ready=0, second token 9'h0F0 -> in_e stays 1, no capture; rcv_ready=1 -> 9'h1A5 consumed, then 9'h0F0 captured.
//  4 Send 9'h155, out_e=1 -> out_rails one-hot per bit; out_e=0 -> rails 0; out_e=1 -> snd_ready=1.
//  5 Multi-hot digit: digit3 rails both high -> no capture until corrected to single rail.
//  6 M=2,N=4: snd_data=4'b1110 -> digit0 rail2, digit1 rail3 high; loopback to receive returns 4'b1110.

Source files
------------

// File: rtl/e1ofn_pkg.sv
// Shared types and token helpers for the e1ofN <-> valid/ready bridge.
// Helpers work on zero-padded maximum-size vectors so one package serves every M/N.
package e1ofn_pkg;

  localparam int unsigned MAX_M     = 32;
  localparam int unsigned MAX_N     = 16;
  localparam int unsigned MAX_L     = 4;
  localparam int unsigned MAX_RAILS = MAX_M * MAX_N;

  typedef enum logic {
    RX_WAIT,
    RX_ACK
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_DATA,
    TX_NEUT
  } tx_state_t;

  // Index of the hot rail; only meaningful when the digit is exactly one-hot.
  function automatic logic [MAX_L-1:0] onehot_digit_to_bin(input logic [MAX_N-1:0] rails);
    logic [MAX_L-1:0] val;
    val = '0;
    for (int unsigned r = 0; r < MAX_N; r++) begin
      if (rails[r]) val = val | MAX_L'(r);
    end
    return val;
  endfunction

  // Values that have no rail in an n-rail digit saturate to the top rail.
  function automatic logic [MAX_N-1:0] bin_to_onehot_digit(input logic [MAX_L-1:0] val,
                                                           input int unsigned     n);
    logic [MAX_L-1:0] clamped;
    clamped = (32'(val) >= n) ? MAX_L'(n - 1) : val;
    return MAX_N'(1) << clamped;
  endfunction

  function automatic logic token_complete(input logic [MAX_RAILS-1:0] rails,
                                          input int unsigned         m,
                                          input int unsigned         n);
    logic        ok;
    int unsigned hot;
    ok = 1'b1;
    for (int unsigned i = 0; i < MAX_M; i++) begin
      if (i < m) begin
        hot = 0;
        for (int unsigned r = 0; r < MAX_N; r++) begin
          if (r < n && rails[i*n + r]) hot++;
        end
        if (hot != 1) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Caller zero-pads unused rails, so the whole vector can be tested.
  function automatic logic token_neutral(input logic [MAX_RAILS-1:0] rails);
    return ~|rails;
  endfunction

endpackage

// File: rtl/e1ofn_sync.sv
// Parameterised-width two-flop synchronizer for the asynchronous e1ofN inputs.
module e1ofn_sync
  import e1ofn_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/e1ofn_rtl_bridge.sv
// Bridges an M-digit 1-of-N channel pair to clocked valid/ready handshakes.
// Define E1OFN_SYNC_EN to pass in_rails/out_e through two-flop synchronizers.
module e1ofn_rtl_bridge
  import e1ofn_pkg::*;
#(
  parameter  int unsigned M = 9,
  parameter  int unsigned N = 2,
  localparam int unsigned L = $clog2(N),
  localparam int unsigned W = M * L
) (
  input  logic           CLK,
  input  logic           _RESET,
  input  logic [M*N-1:0] in_rails,
  output logic           in_e,
  output logic [W-1:0]   rcv_data,
  output logic           rcv_valid,
  input  logic           rcv_ready,
  input  logic [W-1:0]   snd_data,
  input  logic           snd_valid,
  output logic           snd_ready,
  output logic [M*N-1:0] out_rails,
  input  logic           out_e
);

  if (M < 1 || M > MAX_M || N < 2 || N > MAX_N) begin : g_bad_params
    $error("e1ofn_rtl_bridge: M/N outside supported range");
  end

  logic [M*N-1:0] rails_s;
  logic           out_e_s;

`ifdef E1OFN_SYNC_EN
  e1ofn_sync #(.WIDTH(M*N)) u_sync_rails (
    .clk_i (CLK),
    .rst_i (_RESET),
    .d_i   (in_rails),
    .q_o   (rails_s)
  );

  e1ofn_sync #(.WIDTH(1)) u_sync_out_e (
    .clk_i (CLK),
    .rst_i (_RESET),
    .d_i   (out_e),
    .q_o   (out_e_s)
  );
`else
  assign rails_s = in_rails;
  assign out_e_s = out_e;
`endif

  rx_state_t      rx_q, rx_d;
  logic           in_e_q, in_e_d;
  logic [W-1:0]   rcv_data_q, rcv_data_d;
  logic           rcv_valid_q, rcv_valid_d;

  tx_state_t      tx_q, tx_d;
  logic [M*N-1:0] out_rails_q, out_rails_d;
  logic           snd_ready_q, snd_ready_d;

  logic [MAX_RAILS-1:0] rails_ext;
  logic                 rx_complete;
  logic                 rx_neutral;
  logic [W-1:0]         rx_word;
  logic [M*N-1:0]       tx_word;
  logic [MAX_N-1:0]     dec_digit;
  logic [MAX_L-1:0]     dec_val;
  logic [MAX_L-1:0]     enc_val;
  logic [MAX_N-1:0]     enc_digit;
  logic                 consume;

  always_comb begin
    rails_ext            = '0;
    rails_ext[M*N-1:0]   = rails_s;
    rx_complete          = token_complete(rails_ext, M, N);
    rx_neutral           = token_neutral(rails_ext);
    rx_word              = '0;
    dec_digit            = '0;
    dec_val              = '0;
    for (int unsigned i = 0; i < M; i++) begin
      dec_digit          = '0;
      dec_digit[N-1:0]   = rails_s[i*N +: N];
      dec_val            = onehot_digit_to_bin(dec_digit);
      rx_word[i*L +: L]  = dec_val[L-1:0];
    end
  end

  always_comb begin
    tx_word              = '0;
    enc_val              = '0;
    enc_digit            = '0;
    for (int unsigned i = 0; i < M; i++) begin
      enc_val            = '0;
      enc_val[L-1:0]     = snd_data[i*L +: L];
      enc_digit          = bin_to_onehot_digit(enc_val, N);
      tx_word[i*N +: N]  = enc_digit[N-1:0];
    end
  end

  // A consume and a capture may coincide: the single buffer refills without a bubble.
  always_comb begin
    rx_d        = rx_q;
    rcv_data_d  = rcv_data_q;
    rcv_valid_d = rcv_valid_q;
    consume     = rcv_valid_q & rcv_ready;
    if (consume) rcv_valid_d = 1'b0;
    unique case (rx_q)
      RX_WAIT: begin
        if (rx_complete && (!rcv_valid_q || consume)) begin
          rx_d        = RX_ACK;
          rcv_data_d  = rx_word;
          rcv_valid_d = 1'b1;
        end
      end
      RX_ACK: begin
        if (rx_neutral) rx_d = RX_WAIT;
      end
      default: rx_d = RX_WAIT;
    endcase
    in_e_d = (rx_d == RX_WAIT);
  end

  always_comb begin
    tx_d        = tx_q;
    out_rails_d = out_rails_q;
    unique case (tx_q)
      TX_IDLE: begin
        if (snd_valid && snd_ready_q) begin
          out_rails_d = tx_word;
          tx_d        = TX_DATA;
        end
      end
      TX_DATA: begin
        if (!out_e_s) begin
          out_rails_d = '0;
          tx_d        = TX_NEUT;
        end
      end
      TX_NEUT: begin
        if (out_e_s) tx_d = TX_IDLE;
      end
      default: begin
        out_rails_d = '0;
        tx_d        = TX_IDLE;
      end
    endcase
    snd_ready_d = (tx_d == TX_IDLE) && out_e_s;
  end

  always_ff @(posedge CLK) begin
    if (_RESET) begin
      rx_q        <= RX_WAIT;
      in_e_q      <= 1'b1;
      rcv_data_q  <= '0;
      rcv_valid_q <= 1'b0;
      tx_q        <= TX_IDLE;
      out_rails_q <= '0;
      snd_ready_q <= 1'b0;
    end else begin
      rx_q        <= rx_d;
      in_e_q      <= in_e_d;
      rcv_data_q  <= rcv_data_d;
      rcv_valid_q <= rcv_valid_d;
      tx_q        <= tx_d;
      out_rails_q <= out_rails_d;
      snd_ready_q <= snd_ready_d;
    end
  end

  assign in_e      = in_e_q;
  assign rcv_data  = rcv_data_q;
  assign rcv_valid = rcv_valid_q;
  assign snd_ready = snd_ready_q;
  assign out_rails = out_rails_q;

endmodule

// File: tb/tb_e1ofn_rtl_bridge.sv
// Scoreboard bench: M=9/N=2 instance driven as async peer, M=2/N=4 instance in loopback.
module tb_e1ofn_rtl_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [17:0] a_in_rails;
  logic        a_in_e;
  logic [8:0]  a_rcv_data;
  logic        a_rcv_valid, a_rcv_ready;
  logic [8:0]  a_snd_data;
  logic        a_snd_valid, a_snd_ready;
  logic [17:0] a_out_rails;
  logic        a_out_e;

  logic [7:0]  b_rails;
  logic        b_e;
  logic [3:0]  b_rcv_data;
  logic        b_rcv_valid, b_rcv_ready;
  logic [3:0]  b_snd_data;
  logic        b_snd_valid, b_snd_ready;

  e1ofn_rtl_bridge #(.M(9), .N(2)) dut_a (
    .CLK(clk), ._RESET(rst),
    .in_rails(a_in_rails), .in_e(a_in_e),
    .rcv_data(a_rcv_data), .rcv_valid(a_rcv_valid), .rcv_ready(a_rcv_ready),
    .snd_data(a_snd_data), .snd_valid(a_snd_valid), .snd_ready(a_snd_ready),
    .out_rails(a_out_rails), .out_e(a_out_e)
  );

  e1ofn_rtl_bridge #(.M(2), .N(4)) dut_b (
    .CLK(clk), ._RESET(rst),
    .in_rails(b_rails), .in_e(b_e),
    .rcv_data(b_rcv_data), .rcv_valid(b_rcv_valid), .rcv_ready(b_rcv_ready),
    .snd_data(b_snd_data), .snd_valid(b_snd_valid), .snd_ready(b_snd_ready),
    .out_rails(b_rails), .out_e(b_e)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int qa_rx[$];
  int qa_tx[$];
  int qb[$];
  bit rx_done = 0, tx_done = 0, b_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Radix-n digit decomposition of w; digit i drives rail i*n + digit.
  function automatic logic [31:0] enc_model(input int unsigned w, input int unsigned m,
                                            input int unsigned n);
    logic [31:0] r;
    int unsigned rest;
    r = '0;
    rest = w;
    for (int unsigned i = 0; i < m; i++) begin
      r[i*n + rest % n] = 1'b1;
      rest = rest / n;
    end
    return r;
  endfunction

  function automatic int dec_model(input logic [31:0] r, input int m, input int n);
    int val, scale, hot, d;
    val = 0;
    scale = 1;
    for (int i = 0; i < m; i++) begin
      hot = 0;
      d = 0;
      for (int v = 0; v < n; v++) if (r[i*n + v]) begin hot++; d = v; end
      if (hot != 1) return -1;
      val += d * scale;
      scale *= n;
    end
    return val;
  endfunction

  function automatic logic [17:0] enc_a(input int unsigned w);
    logic [31:0] t;
    t = enc_model(w, 9, 2);
    return t[17:0];
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return a_in_e;
      1:       return a_snd_ready;
      2:       return b_snd_ready;
      default: return (a_out_rails == '0);
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input int sel, input logic val, input int budget, input string name);
    int g;
    g = 0;
    while (sig(sel) !== val && g < budget) begin
      cyc();
      g++;
    end
    if (sig(sel) !== val) begin
      n_total++;
      $display("FAIL %s: timeout after %0d cycles, got %0b expected %0b", name, budget, sig(sel), val);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && a_rcv_valid && a_rcv_ready) begin
      if (qa_rx.size() == 0) begin
        n_total++;
        $display("FAIL a_rx_extra: got 0x%0h, expected no word", a_rcv_data);
      end else check("a_rx_data", 32'(a_rcv_data), 32'(qa_rx.pop_front()));
    end
    if (!rst && b_rcv_valid && b_rcv_ready) begin
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL b_rx_extra: got 0x%0h, expected no word", b_rcv_data);
      end else check("b_loop_data", 32'(b_rcv_data), 32'(qb.pop_front()));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst = 1'b1;
    a_in_rails = '0; a_rcv_ready = 1'b0; a_snd_data = '0; a_snd_valid = 1'b0; a_out_e = 1'b0;
    b_rcv_ready = 1'b0; b_snd_data = '0; b_snd_valid = 1'b0;
    cyc(); cyc();
    check("rst_in_e", 32'(a_in_e), 32'd1);
    check("rst_rcv_valid", 32'(a_rcv_valid), 32'd0);
    check("rst_rcv_data", 32'(a_rcv_data), 32'd0);
    check("rst_out_rails", 32'(a_out_rails), 32'd0);
    check("rst_snd_ready", 32'(a_snd_ready), 32'd0);
    rst = 1'b0;
    a_out_e = 1'b1;
    cyc();

    // Reset while a captured token is still on the rails
    a_in_rails = enc_a(9'h1A5);
    cyc();
    check("midtok_captured", 32'(a_rcv_valid), 32'd1);
    rst = 1'b1;
    cyc(); cyc();
    check("midtok_rst_in_e", 32'(a_in_e), 32'd1);
    check("midtok_rst_valid", 32'(a_rcv_valid), 32'd0);
    check("midtok_rst_data", 32'(a_rcv_data), 32'd0);
    check("midtok_rst_rails", 32'(a_out_rails), 32'd0);
    a_in_rails = '0;
    rst = 1'b0;
    cyc();

    // Receive 9'h1A5 with consumer stalled
    a_in_rails = enc_a(9'h1A5);
    cyc();
    check("rx_valid", 32'(a_rcv_valid), 32'd1);
    check("rx_data", 32'(a_rcv_data), 32'h1A5);
    check("rx_ack_in_e", 32'(a_in_e), 32'd0);
    a_in_rails = '0;
    cyc();
    check("rx_neutral_in_e", 32'(a_in_e), 32'd1);

    // Backpressure: second token must wait for the buffered word to leave
    a_in_rails = enc_a(9'h0F0);
    cyc(); cyc(); cyc();
    check("bp_in_e_high", 32'(a_in_e), 32'd1);
    check("bp_data_held", 32'(a_rcv_data), 32'h1A5);
    check("bp_valid_held", 32'(a_rcv_valid), 32'd1);
    qa_rx.push_back(9'h1A5);
    qa_rx.push_back(9'h0F0);
    a_rcv_ready = 1'b1;
    cyc();
    check("bp_refill_data", 32'(a_rcv_data), 32'h0F0);
    check("bp_refill_valid", 32'(a_rcv_valid), 32'd1);
    check("bp_refill_in_e", 32'(a_in_e), 32'd0);
    a_in_rails = '0;
    cyc();
    check("bp_drain_valid", 32'(a_rcv_valid), 32'd0);
    check("bp_drain_in_e", 32'(a_in_e), 32'd1);

    // Multi-hot digit 3 blocks capture until corrected
    a_in_rails = enc_a(9'h0AB) | 18'(3 << 6);
    cyc(); cyc(); cyc();
    check("mh_no_capture", 32'(a_rcv_valid), 32'd0);
    check("mh_in_e", 32'(a_in_e), 32'd1);
    qa_rx.push_back(9'h0AB);
    a_in_rails = enc_a(9'h0AB);
    cyc();
    check("mh_fixed_valid", 32'(a_rcv_valid), 32'd1);
    check("mh_fixed_in_e", 32'(a_in_e), 32'd0);
    a_in_rails = '0;
    cyc(); cyc();
    check("mh_done_in_e", 32'(a_in_e), 32'd1);

    // Send 9'h155
    check("tx_ready_idle", 32'(a_snd_ready), 32'd1);
    a_snd_data = 9'h155;
    a_snd_valid = 1'b1;
    cyc();
    a_snd_valid = 1'b0;
    check("tx_rails", 32'(a_out_rails), 32'(enc_a(9'h155)));
    check("tx_ready_busy", 32'(a_snd_ready), 32'd0);
    cyc();
    check("tx_rails_hold", 32'(a_out_rails), 32'(enc_a(9'h155)));
    a_out_e = 1'b0;
    cyc();
    check("tx_rails_neutral", 32'(a_out_rails), 32'd0);
    cyc();
    check("tx_neut_ready", 32'(a_snd_ready), 32'd0);
    a_out_e = 1'b1;
    cyc();
    check("tx_ready_again", 32'(a_snd_ready), 32'd1);

    // M=2,N=4 loopback of 4'b1110
    b_rcv_ready = 1'b1;
    check("lb_ready", 32'(b_snd_ready), 32'd1);
    qb.push_back(4'b1110);
    b_snd_data = 4'b1110;
    b_snd_valid = 1'b1;
    cyc();
    b_snd_valid = 1'b0;
    check("lb_rails", 32'(b_rails), 32'h84);
    repeat (6) cyc();
    check("lb_rails_idle", 32'(b_rails), 32'd0);
    check("lb_ready_again", 32'(b_snd_ready), 32'd1);
    check("lb_drained", 32'(qb.size()), 32'd0);

    // Randomised traffic on all three paths concurrently
    fork
      begin : a_rx_src
        for (int k = 0; k < 40; k++) begin
          wait_for(0, 1'b1, 200, "rand_rx_wait_e_high");
          w = int'($urandom_range(511));
          a_in_rails = enc_a(w);
          qa_rx.push_back(w);
          wait_for(0, 1'b0, 200, "rand_rx_wait_ack");
          repeat ($urandom_range(2)) cyc();
          a_in_rails = '0;
        end
        rx_done = 1;
      end
      begin : a_rx_ready
        for (int g = 0; g < 5000 && !(rx_done && qa_rx.size() == 0); g++) begin
          cyc();
          a_rcv_ready = ($urandom_range(3) != 0);
        end
        a_rcv_ready = 1'b1;
      end
      begin : a_tx_src
        int tw;
        for (int k = 0; k < 30; k++) begin
          tw = int'($urandom_range(511));
          a_snd_data = 9'(tw);
          a_snd_valid = 1'b1;
          wait_for(1, 1'b1, 200, "rand_tx_wait_ready");
          qa_tx.push_back(tw);
          cyc();
          a_snd_valid = 1'b0;
          repeat ($urandom_range(3)) cyc();
        end
        tx_done = 1;
      end
      begin : a_tx_sink
        int v;
        for (int g = 0; g < 5000 && !(tx_done && qa_tx.size() == 0); g++) begin
          cyc();
          if (a_out_e && a_out_rails != '0) begin
            v = dec_model(32'(a_out_rails), 9, 2);
            if (qa_tx.size() == 0) begin
              n_total++;
              $display("FAIL a_tx_extra: got 0x%0h, expected no token", a_out_rails);
            end else check("a_tx_data", 32'(v), 32'(qa_tx.pop_front()));
            repeat ($urandom_range(2)) cyc();
            a_out_e = 1'b0;
            wait_for(3, 1'b1, 50, "rand_tx_wait_neutral");
            repeat ($urandom_range(2)) cyc();
            a_out_e = 1'b1;
          end
        end
      end
      begin : b_src
        int bw;
        for (int k = 0; k < 30; k++) begin
          bw = int'($urandom_range(15));
          b_snd_data = 4'(bw);
          b_snd_valid = 1'b1;
          wait_for(2, 1'b1, 200, "rand_lb_wait_ready");
          qb.push_back(bw);
          cyc();
          b_snd_valid = 1'b0;
          repeat ($urandom_range(2)) cyc();
        end
        b_done = 1;
      end
      begin : b_ready
        for (int g = 0; g < 5000 && !(b_done && qb.size() == 0); g++) begin
          cyc();
          b_rcv_ready = ($urandom_range(2) != 0);
        end
        b_rcv_ready = 1'b1;
      end
    join

    repeat (10) cyc();
    check("end_a_rx_drained", 32'(qa_rx.size()), 32'd0);
    check("end_a_tx_drained", 32'(qa_tx.size()), 32'd0);
    check("end_b_drained", 32'(qb.size()), 32'd0);
    check("end_a_in_e", 32'(a_in_e), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
